// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the tile DMEM arbiter and its reservation register.
package dmem_arbiter_pkg;

    localparam int dmem_arb_max_net_wait_gp = 8;

    // Address width that never collapses to zero for a one-entry memory.
    function automatic int safe_clog2(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request, DMEM-port and read-return signals between requesters, the arbiter and the DMEM macro.
interface dmem_arbiter_if #(
    parameter int data_width_p = 32,
    parameter int dmem_size_p  = 1024
);
    import dmem_arbiter_pkg::*;

    localparam int dmem_addr_width_lp = safe_clog2(dmem_size_p);
    localparam int data_mask_width_lp = data_width_p >> 3;

    logic                          core_v_i;
    logic                          core_w_i;
    logic [dmem_addr_width_lp-1:0] core_addr_i;
    logic [data_width_p-1:0]       core_data_i;
    logic [data_mask_width_lp-1:0] core_mask_i;
    logic                          core_reserve_i;
    logic                          core_clear_reserve_i;
    logic                          core_yumi_o;

    logic                          net_v_i;
    logic                          net_w_i;
    logic [dmem_addr_width_lp-1:0] net_addr_i;
    logic [data_width_p-1:0]       net_data_i;
    logic [data_mask_width_lp-1:0] net_mask_i;
    logic                          net_yumi_o;

    logic                          mem_v_o;
    logic                          mem_w_o;
    logic [dmem_addr_width_lp-1:0] mem_addr_o;
    logic [data_width_p-1:0]       mem_data_o;
    logic [data_mask_width_lp-1:0] mem_mask_o;
    logic [data_width_p-1:0]       mem_data_i;

    logic                          core_rdata_v_o;
    logic                          net_rdata_v_o;
    logic [data_width_p-1:0]       rdata_o;
    logic                          reserved_o;
    logic [dmem_addr_width_lp-1:0] reserved_addr_o;
    logic                          break_reserve_o;

    modport slave (
        input  core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i,
               core_reserve_i, core_clear_reserve_i,
               net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
               mem_data_i,
        output core_yumi_o, net_yumi_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
               core_rdata_v_o, net_rdata_v_o, rdata_o,
               reserved_o, reserved_addr_o, break_reserve_o
    );

    modport master (
        output core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i,
               core_reserve_i, core_clear_reserve_i,
               net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
               mem_data_i,
        input  core_yumi_o, net_yumi_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
               core_rdata_v_o, net_rdata_v_o, rdata_o,
               reserved_o, reserved_addr_o, break_reserve_o
    );

endinterface

// File: rtl/dmem_arbiter_reservation.sv
// Load-reserved reservation register: set by a granted LR, killed by a granted write to the
// reserved word (with a one-cycle break pulse) or dropped silently on a core clear.
module dmem_reservation #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    set_v_i,
    input  logic [addr_width_p-1:0] set_addr_i,
    input  logic                    write_v_i,
    input  logic [addr_width_p-1:0] write_addr_i,
    input  logic                    clear_i,
    output logic                    reserved_o,
    output logic [addr_width_p-1:0] reserved_addr_o,
    output logic                    break_reserve_o
);

    // Set beats break beats clear; a set and a break never share a cycle since only one grant exists.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            reserved_o      <= 1'b0;
            reserved_addr_o <= {addr_width_p{1'b0}};
            break_reserve_o <= 1'b0;
        end else begin
            break_reserve_o <= 1'b0;
            if (set_v_i) begin
                reserved_o      <= 1'b1;
                reserved_addr_o <= set_addr_i;
            end else if (write_v_i && reserved_o && (write_addr_i == reserved_addr_o)) begin
                reserved_o      <= 1'b0;
                break_reserve_o <= 1'b1;
            end else if (clear_i) begin
                reserved_o      <= 1'b0;
            end else begin
                reserved_o      <= reserved_o;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the core LSU and the network endpoint, with bounded network
// starvation, 1-cycle read-return routing and the LR reservation register.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int dmem_size_p    = 1024,
    parameter int max_net_wait_p = dmem_arb_max_net_wait_gp
) (
    input  logic           clk_i,
    input  logic           reset_i,
    dmem_arbiter_if.slave  bus
);

    localparam int dmem_addr_width_lp = safe_clog2(dmem_size_p);
    localparam int data_mask_width_lp = data_width_p >> 3;
    localparam int starve_width_lp    = safe_clog2(max_net_wait_p + 1);
    localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(max_net_wait_p);
    localparam logic [starve_width_lp-1:0] starve_one_lp = starve_width_lp'(1);

    logic [starve_width_lp-1:0] starve_cnt;
    logic                       net_win_s;
    logic                       core_rd_r;
    logic                       net_rd_r;
    logic                       resv_set_s;
    logic                       mem_write_s;

    // Core wins unless it is idle or the network has lost the maximum number of times in a row.
    always_comb begin
        net_win_s = 1'b0;
        if (bus.net_v_i && (!bus.core_v_i || (starve_cnt == starve_max_lp))) begin
            net_win_s = 1'b1;
        end else begin
            net_win_s = 1'b0;
        end
    end

    assign bus.net_yumi_o  = net_win_s;
    assign bus.core_yumi_o = bus.core_v_i & ~net_win_s;
    assign bus.mem_v_o     = bus.core_yumi_o | bus.net_yumi_o;

    // DMEM port fields follow the winner; with no grant they show the core request.
    always_comb begin
        bus.mem_w_o    = bus.core_w_i;
        bus.mem_addr_o = bus.core_addr_i;
        bus.mem_data_o = bus.core_data_i;
        bus.mem_mask_o = bus.core_mask_i;
        if (net_win_s) begin
            bus.mem_w_o    = bus.net_w_i;
            bus.mem_addr_o = bus.net_addr_i;
            bus.mem_data_o = bus.net_data_i;
            bus.mem_mask_o = bus.net_mask_i;
        end else begin
            bus.mem_w_o    = bus.core_w_i;
            bus.mem_addr_o = bus.core_addr_i;
            bus.mem_data_o = bus.core_data_i;
            bus.mem_mask_o = bus.core_mask_i;
        end
    end

    // Consecutive lost arbitrations of a pending network request, saturating at the limit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= {starve_width_lp{1'b0}};
        end else if (!bus.net_v_i || bus.net_yumi_o) begin
            starve_cnt <= {starve_width_lp{1'b0}};
        end else if (starve_cnt != starve_max_lp) begin
            starve_cnt <= starve_cnt + starve_one_lp;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end

    // Read-return tag: remembers which requester owns next cycle's DMEM read data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            core_rd_r <= 1'b0;
            net_rd_r  <= 1'b0;
        end else begin
            core_rd_r <= bus.core_yumi_o & ~bus.core_w_i;
            net_rd_r  <= bus.net_yumi_o & ~bus.net_w_i;
        end
    end

    assign bus.core_rdata_v_o = core_rd_r;
    assign bus.net_rdata_v_o  = net_rd_r;
    assign bus.rdata_o        = bus.mem_data_i;

    assign resv_set_s  = bus.core_yumi_o & ~bus.core_w_i & bus.core_reserve_i;
    assign mem_write_s = bus.mem_v_o & bus.mem_w_o;

    dmem_reservation #(
        .addr_width_p (dmem_addr_width_lp)
    ) reservation (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .set_v_i         (resv_set_s),
        .set_addr_i      (bus.core_addr_i),
        .write_v_i       (mem_write_s),
        .write_addr_i    (bus.mem_addr_o),
        .clear_i         (bus.core_clear_reserve_i),
        .reserved_o      (bus.reserved_o),
        .reserved_addr_o (bus.reserved_addr_o),
        .break_reserve_o (bus.break_reserve_o)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency DMEM model.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dmem_arbiter_if #(.data_width_p(32), .dmem_size_p(256)) bus ();

    dmem_arbiter #(
        .data_width_p   (32),
        .dmem_size_p    (256),
        .max_net_wait_p (8)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM model: unwritten words read as 32'hA500_00xx where xx is the address.
    logic [31:0] mem [int];
    always @(posedge clk) begin
        logic [31:0] old;
        int a;
        a = int'(bus.mem_addr_o);
        old = mem.exists(a) ? mem[a] : (32'hA500_0000 | 32'(bus.mem_addr_o));
        if (bus.mem_v_o && !bus.mem_w_o) bus.mem_data_i <= old;
        if (bus.mem_v_o && bus.mem_w_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_mask_o[b]) old[b*8 +: 8] = bus.mem_data_o[b*8 +: 8];
            mem[a] = old;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_req(input logic v, input logic w, input logic [7:0] addr,
                            input logic [31:0] data, input logic rsv, input logic clr);
        bus.core_v_i             = v;
        bus.core_w_i             = w;
        bus.core_addr_i          = addr;
        bus.core_data_i          = data;
        bus.core_mask_i          = 4'hF;
        bus.core_reserve_i       = rsv;
        bus.core_clear_reserve_i = clr;
    endtask

    task automatic net_req(input logic v, input logic w, input logic [7:0] addr,
                           input logic [31:0] data);
        bus.net_v_i    = v;
        bus.net_w_i    = w;
        bus.net_addr_i = addr;
        bus.net_data_i = data;
        bus.net_mask_i = 4'hF;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.mem_data_i = 32'h0;
        core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        net_req(1'b0, 1'b0, 8'h00, 32'h0);

        // Reset state, and combinational grant during reset
        tick();
        tick();
        chk("rst_core_rdata_v", 32'(bus.core_rdata_v_o), 32'd0);
        chk("rst_net_rdata_v", 32'(bus.net_rdata_v_o), 32'd0);
        chk("rst_reserved", 32'(bus.reserved_o), 32'd0);
        chk("rst_reserved_addr", 32'(bus.reserved_addr_o), 32'd0);
        chk("rst_break", 32'(bus.break_reserve_o), 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
        core_req(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_comb_core_yumi", 32'(bus.core_yumi_o), 32'd1);
        tick();
        reset = 1'b0;
        core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        #1;
        chk("post_rst_rdata_v", 32'(bus.core_rdata_v_o), 32'd0);

        // Back-to-back core reads
        tick(); core_req(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0); #1;
        chk("rd0_yumi", 32'(bus.core_yumi_o), 32'd1);
        chk("rd0_mem_addr", 32'(bus.mem_addr_o), 32'h10);
        chk("rd0_mem_v", 32'(bus.mem_v_o), 32'd1);
        tick(); core_req(1'b1, 1'b0, 8'h11, 32'h0, 1'b0, 1'b0); #1;
        chk("rd1_yumi", 32'(bus.core_yumi_o), 32'd1);
        chk("rd0_rdata_v", 32'(bus.core_rdata_v_o), 32'd1);
        chk("rd0_rdata", bus.rdata_o, 32'hA500_0010);
        tick(); core_req(1'b1, 1'b0, 8'h12, 32'h0, 1'b0, 1'b0); #1;
        chk("rd2_yumi", 32'(bus.core_yumi_o), 32'd1);
        chk("rd1_rdata_v", 32'(bus.core_rdata_v_o), 32'd1);
        chk("rd1_rdata", bus.rdata_o, 32'hA500_0011);
        tick(); core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); #1;
        chk("rd2_rdata_v", 32'(bus.core_rdata_v_o), 32'd1);
        chk("rd2_rdata", bus.rdata_o, 32'hA500_0012);
        chk("idle_mem_v", 32'(bus.mem_v_o), 32'd0);
        tick(); #1;
        chk("rd_done_rdata_v", 32'(bus.core_rdata_v_o), 32'd0);

        // Starvation bound: network wins exactly on the 9th contended cycle
        for (int c = 1; c <= 12; c++) begin
            tick();
            core_req(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
            net_req(1'b1, 1'b0, 8'h01, 32'h0);
            #1;
            chk($sformatf("stv_net_yumi_c%0d", c), 32'(bus.net_yumi_o), (c == 9) ? 32'd1 : 32'd0);
            chk($sformatf("stv_core_yumi_c%0d", c), 32'(bus.core_yumi_o), (c == 9) ? 32'd0 : 32'd1);
            chk($sformatf("stv_cnt_c%0d", c), 32'(dut.starve_cnt), (c <= 9) ? 32'(c - 1) : 32'(c - 10));
            chk($sformatf("stv_net_rdv_c%0d", c), 32'(bus.net_rdata_v_o), (c == 10) ? 32'd1 : 32'd0);
            if (c == 10) chk("stv_net_rdata", bus.rdata_o, 32'hA500_0001);
        end
        tick();
        core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        net_req(1'b0, 1'b0, 8'h00, 32'h0);
        #1;

        // Network write while core idle
        tick();
        net_req(1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF);
        #1;
        chk("nw_net_yumi", 32'(bus.net_yumi_o), 32'd1);
        chk("nw_core_yumi", 32'(bus.core_yumi_o), 32'd0);
        chk("nw_mem_w", 32'(bus.mem_w_o), 32'd1);
        chk("nw_mem_addr", 32'(bus.mem_addr_o), 32'h20);
        chk("nw_mem_data", bus.mem_data_o, 32'hDEAD_BEEF);
        chk("nw_mem_mask", 32'(bus.mem_mask_o), 32'hF);
        tick();
        net_req(1'b0, 1'b0, 8'h00, 32'h0);
        core_req(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0);
        #1;
        chk("nw_no_core_rdv", 32'(bus.core_rdata_v_o), 32'd0);
        chk("nw_no_net_rdv", 32'(bus.net_rdata_v_o), 32'd0);
        tick();
        core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        #1;
        chk("nw_readback_v", 32'(bus.core_rdata_v_o), 32'd1);
        chk("nw_readback", bus.rdata_o, 32'hDEAD_BEEF);

        // LR to 0x30, write to 0x31 keeps it, write to 0x30 breaks it
        tick(); core_req(1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0); #1;
        chk("lr30_yumi", 32'(bus.core_yumi_o), 32'd1);
        tick(); core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); #1;
        chk("lr30_reserved", 32'(bus.reserved_o), 32'd1);
        chk("lr30_addr", 32'(bus.reserved_addr_o), 32'h30);
        tick(); net_req(1'b1, 1'b1, 8'h31, 32'h1234_5678); #1;
        chk("w31_net_yumi", 32'(bus.net_yumi_o), 32'd1);
        tick(); net_req(1'b0, 1'b0, 8'h00, 32'h0); #1;
        chk("w31_reserved", 32'(bus.reserved_o), 32'd1);
        chk("w31_break", 32'(bus.break_reserve_o), 32'd0);
        tick(); net_req(1'b1, 1'b1, 8'h30, 32'h1111_2222); #1;
        tick(); net_req(1'b0, 1'b0, 8'h00, 32'h0); #1;
        chk("w30_break", 32'(bus.break_reserve_o), 32'd1);
        chk("w30_reserved", 32'(bus.reserved_o), 32'd0);
        tick(); #1;
        chk("w30_break_once", 32'(bus.break_reserve_o), 32'd0);

        // LR with simultaneous clear: set wins; later clear drops it silently
        tick(); core_req(1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b1); #1;
        tick(); core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); #1;
        chk("lr40_reserved", 32'(bus.reserved_o), 32'd1);
        chk("lr40_addr", 32'(bus.reserved_addr_o), 32'h40);
        tick(); core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1); #1;
        tick(); core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); #1;
        chk("clr_reserved", 32'(bus.reserved_o), 32'd0);
        chk("clr_no_break", 32'(bus.break_reserve_o), 32'd0);

        // Reset mid-operation drops tag, reservation and starvation count
        tick();
        core_req(1'b1, 1'b0, 8'h50, 32'h0, 1'b1, 1'b0);
        net_req(1'b1, 1'b0, 8'h02, 32'h0);
        #1;
        chk("mr_core_yumi", 32'(bus.core_yumi_o), 32'd1);
        chk("mr_net_yumi", 32'(bus.net_yumi_o), 32'd0);
        tick();
        reset = 1'b1;
        core_req(1'b1, 1'b0, 8'h51, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mr_pre_starve", 32'(dut.starve_cnt), 32'd1);
        chk("mr_pre_reserved", 32'(bus.reserved_o), 32'd1);
        chk("mr_pre_raddr", 32'(bus.reserved_addr_o), 32'h50);
        tick();
        reset = 1'b0;
        core_req(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        net_req(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("mr_core_rdata_v", 32'(bus.core_rdata_v_o), 32'd0);
        chk("mr_net_rdata_v", 32'(bus.net_rdata_v_o), 32'd0);
        chk("mr_reserved", 32'(bus.reserved_o), 32'd0);
        chk("mr_reserved_addr", 32'(bus.reserved_addr_o), 32'd0);
        chk("mr_starve", 32'(dut.starve_cnt), 32'd0);
        chk("mr_break", 32'(bus.break_reserve_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-ported tile DMEM bank, sharing it between the core load/store path and incoming network-endpoint requests. It picks one requester per cycle, drives the DMEM port, and routes the 1-cycle-latency read data back to the winner. It also owns the load-reserved (LR) reservation register, which is broken by any granted write to the reserved word. It sits between the LSU/EXE stage and the DMEM macro, alongside the endpoint receive path.

## Interface
Parameters:
- data_width_p, none (must set), word width; 32 in all tiles.
- dmem_size_p, none (must set), DMEM depth in words.
- max_net_wait_p, 8, maximum consecutive cycles a pending network request can lose arbitration to the core.
- dmem_addr_width_lp, `BSG_SAFE_CLOG2(dmem_size_p)`, derived.
- data_mask_width_lp, data_width_p>>3, derived.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- core_v_i / core_w_i  in  1/1  core request valid / write.
- core_addr_i  in  dmem_addr_width_lp  core word address.
- core_data_i / core_mask_i  in  data_width_p / data_mask_width_lp  core store data / byte mask.
- core_reserve_i  in  1  core read is an LR; set the reservation on grant.
- core_clear_reserve_i  in  1  core drops its reservation (SC done, or context change).
- core_yumi_o  out  1  core request accepted this cycle; core stalls otherwise.
- net_v_i / net_w_i / net_addr_i / net_data_i / net_mask_i  in  same widths as core  network request.
- net_yumi_o  out  1  network request accepted this cycle.
- mem_v_o / mem_w_o / mem_addr_o / mem_data_o / mem_mask_o  out  1/1/addr/data/mask  DMEM port.
- mem_data_i  in  data_width_p  DMEM read data, valid the cycle after a read access.
- core_rdata_v_o / net_rdata_v_o  out  1/1  read data belongs to core / network.
- rdata_o  out  data_width_p  mem_data_i passed through.
- reserved_o  out  1  reservation valid.
- reserved_addr_o  out  dmem_addr_width_lp  reserved word address.
- break_reserve_o  out  1  one-cycle pulse when a write kills the reservation.

## Operation
- Arbitration (combinational, same cycle):
  - The core wins by default.
  - The network wins when core_v_i=0, or when starve_cnt == max_net_wait_p.
  - At most one of core_yumi_o/net_yumi_o is high; yumi implies the matching v.
- mem_* fields are muxed from the winner. mem_v_o = core_yumi_o | net_yumi_o. When idle, mem_* data/addr fields hold the core inputs.
- starve_cnt (width clog2(max_net_wait_p+1)):
  - Increments when net_v_i & ~net_yumi_o.
  - Clears to 0 when net_yumi_o=1 or net_v_i=0.
  - Saturates at max_net_wait_p.
- Read return: a registered tag {core_rd, net_rd} is set on a granted read (~w). The next cycle it drives core_rdata_v_o/net_rdata_v_o.
- Reservation register {resv_v, resv_addr}, next-state in priority order:
  1. Granted core read with core_reserve_i: set resv_v=1, resv_addr=core_addr_i.
  2. Granted write (core or net) with addr == resv_addr while resv_v=1: clear resv_v and pulse break_reserve_o the next cycle.
  3. core_clear_reserve_i: clear resv_v, no break pulse.
- Only one grant per cycle, so a set and a write-break can never coincide.
- A set in the same cycle as core_clear_reserve_i: the set wins.

## Timing
- Grant and DMEM access: 0-cycle combinational path from *_v_i to yumi and mem_*.
- Read data: exactly 1 cycle after grant. Back-to-back reads return every cycle with no bubble.
- break_reserve_o, reserved_o, reserved_addr_o: registered, visible 1 cycle after the causing grant.
- Worst-case network latency under continuous core traffic: max_net_wait_p+1 cycles from net_v_i to net_yumi_o.
- Reset values: starve_cnt=0; core_rdata_v_o=0; net_rdata_v_o=0; reserved_o=0; reserved_addr_o=0; break_reserve_o=0.
- Combinational outputs (yumi, mem_*) follow inputs during reset. The DMEM content is not protected.
- Reset asserted mid-operation:
  - A read granted the cycle before reset returns no valid (tag cleared).
  - The reservation is dropped.

## Structure
- No new typedefs. The request bundle stays flat ports.
- max_net_wait_p default is a `bsg_vanilla_pkg` constant, dmem_arb_max_net_wait_gp.
- One natural sub-module: dmem_reservation. It holds the reservation register, address compare and break pulse, so the LR/SC checker can instantiate it stand-alone.
- The starvation counter stays inline.

## Test plan
- Core-only reads at addr 0x10,0x11,0x12 on consecutive cycles -> core_yumi_o=1 each cycle; core_rdata_v_o=1 on cycles 2-4 with the matching data.
- core_v_i and net_v_i held high for 12 cycles, max_net_wait_p=8 -> net granted exactly on cycle 9; starve_cnt returns to 0; core granted all other cycles.
- Net write 0xDEADBEEF, mask 4'b1111 to 0x20 while core is idle -> net_yumi_o=1 the same cycle; mem_w_o=1, mem_addr_o=0x20; no rdata valid the next cycle.
- Core LR to 0x30, then net write to 0x30 -> reserved_o=1 after the LR; net write breaks it: break_reserve_o pulses once, reserved_o=0; a write to 0x31 instead leaves reserved_o=1.
- Core LR to 0x40 with core_clear_reserve_i=1 the same cycle -> reserved_o=1, reserved_addr_o=0x40; a later clear alone -> reserved_o=0 with no break pulse.
- Granted core read, then reset_i=1 the next cycle -> core_rdata_v_o=0, reserved_o=0, starve_cnt=0 after reset.
